// File: rtl/instr_enc_pkg.sv
// Shared types and constants for the RV32I program loader.
//  op_e    : request opcode select (lw, sw, beq, illegal)
//  err_e   : first-error code reported by the loader
//  state_e : loader FSM states
//  OPC_* / F3_* : RV32I major opcodes and funct3 values used by the encoder
package instr_enc_pkg;

    typedef enum logic [1:0] {
        OP_LW  = 2'b00,
        OP_SW  = 2'b01,
        OP_BEQ = 2'b10,
        OP_ILL = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'b00,
        ERR_RANGE = 2'b01,
        ERR_ALIGN = 2'b10,
        ERR_OP    = 2'b11
    } err_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        CHECK = 2'b01,
        WRITE = 2'b10,
        FULL  = 2'b11
    } state_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_BEQ = 3'b000;

endpackage

// File: rtl/imm_pack.sv
// Combinational immediate checker and instruction packer.
//  op       in  opcode select
//  rd/rs1/rs2 in register fields
//  imm      in  32-bit signed immediate (byte offset for beq)
//  word     out encoded RV32I instruction (zero for the illegal op)
//  range_ok out immediate fits the format's signed field
//  align_ok out branch offset is halfword aligned (always 1 for lw/sw)
module imm_pack
    import instr_enc_pkg::*;
(
    input  op_e         op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        range_ok,
    output logic        align_ok
);

    logic signed [31:0] simm;
    assign simm = imm;

    always_comb begin
        word     = '0;
        range_ok = 1'b0;
        align_ok = 1'b1;
        case (op)
            OP_LW: begin
                word     = {imm[11:0], rs1, F3_W, rd, OPC_LOAD};
                range_ok = (simm >= -32'sd2048) && (simm <= 32'sd2047);
            end
            OP_SW: begin
                word     = {imm[11:5], rs2, rs1, F3_W, imm[4:0], OPC_STORE};
                range_ok = (simm >= -32'sd2048) && (simm <= 32'sd2047);
            end
            OP_BEQ: begin
                // B-type drops bit 0 and scatters bits 12..1 across the word.
                word     = {imm[12], imm[10:5], rs2, rs1, F3_BEQ, imm[4:1], imm[11], OPC_BRANCH};
                range_ok = (simm >= -32'sd4096) && (simm <= 32'sd4094);
                align_ok = ~imm[0];
            end
            default: begin
                word     = '0;
                range_ok = 1'b0;
                align_ok = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_imm_encoder.sv
// RV32I program loader: accepts lw/sw/beq requests, range-checks the immediate,
// encodes the instruction and writes it to the next IMEM word.
//  clk, rst_n        clock, asynchronous active-low reset
//  clear             synchronous restart (pointer, error and in-flight request)
//  in_valid/in_ready request handshake; in_op/in_rd/in_rs1/in_rs2/in_imm request fields
//  imem_we/imem_addr/imem_wdata  one-cycle IMEM write port
//  wr_count, full    words written so far, and the IMEM-full indication
//  err, err_code     sticky rejection flag and the first error's cause
module instr_imm_encoder
    import instr_enc_pkg::*;
#(
    parameter int IMEM_DEPTH = 64,
    parameter int ADDR_W     = $clog2(IMEM_DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   wr_count,
    output logic              full,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(IMEM_DEPTH);

    state_e           state_reg, state_next;
    op_e              op_reg;
    logic [4:0]       rd_reg, rs1_reg, rs2_reg;
    logic [31:0]      imm_reg;
    logic [31:0]      wdata_reg, wdata_next;
    logic [ADDR_W:0]  count_reg, count_next;
    logic             err_reg, err_next;
    err_e             code_reg, code_next;

    logic [31:0]      pack_word;
    logic             range_ok, align_ok;
    logic             handshake;

    imm_pack u_imm_pack (
        .op       (op_reg),
        .rd       (rd_reg),
        .rs1      (rs1_reg),
        .rs2      (rs2_reg),
        .imm      (imm_reg),
        .word     (pack_word),
        .range_ok (range_ok),
        .align_ok (align_ok)
    );

    // Refusing requests while clear is high keeps a handshake from being
    // acknowledged and then silently discarded by the restart.
    assign in_ready   = (state_reg == IDLE) && !full && !clear;
    assign handshake  = in_valid && in_ready;
    assign imem_we    = (state_reg == WRITE) && !clear;
    assign imem_addr  = count_reg[ADDR_W-1:0];
    assign imem_wdata = wdata_reg;
    assign wr_count   = count_reg;
    assign full       = (count_reg == DEPTH_CNT);
    assign err        = err_reg;
    assign err_code   = code_reg;

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        err_next   = err_reg;
        code_next  = code_reg;
        wdata_next = wdata_reg;
        case (state_reg)
            IDLE: begin
                if (handshake) state_next = CHECK;
            end
            CHECK: begin
                if ((op_reg == OP_ILL) || !range_ok || !align_ok) begin
                    state_next = IDLE;
                    // Only the first rejection's cause is kept.
                    if (!err_reg) begin
                        err_next = 1'b1;
                        if (op_reg == OP_ILL)  code_next = ERR_OP;
                        else if (!range_ok)    code_next = ERR_RANGE;
                        else                   code_next = ERR_ALIGN;
                    end
                end else begin
                    wdata_next = pack_word;
                    state_next = WRITE;
                end
            end
            WRITE: begin
                count_next = count_reg + 1'b1;
                state_next = (count_next == DEPTH_CNT) ? FULL : IDLE;
            end
            default: begin
                state_next = FULL;
            end
        endcase
        // Restart wins over every transition; the last written word is kept.
        if (clear) begin
            state_next = IDLE;
            count_next = '0;
            err_next   = 1'b0;
            code_next  = ERR_NONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            count_reg <= '0;
            err_reg   <= 1'b0;
            code_reg  <= ERR_NONE;
            wdata_reg <= '0;
            op_reg    <= OP_LW;
            rd_reg    <= '0;
            rs1_reg   <= '0;
            rs2_reg   <= '0;
            imm_reg   <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            err_reg   <= err_next;
            code_reg  <= code_next;
            wdata_reg <= wdata_next;
            if (handshake) begin
                op_reg  <= op_e'(in_op);
                rd_reg  <= in_rd;
                rs1_reg <= in_rs1;
                rs2_reg <= in_rs2;
                imm_reg <= in_imm;
            end
        end
    end

endmodule

// File: tb/tb_instr_imm_encoder.sv
// Directed bench for instr_imm_encoder (IMEM_DEPTH=4) with a reference model
// of the encoder/checker and a write scoreboard.
module tb_instr_imm_encoder;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          rst_n, clear, in_valid, in_ready;
    logic [1:0]    in_op;
    logic [4:0]    in_rd, in_rs1, in_rs2;
    logic [31:0]   in_imm;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [AW:0]   wr_count;
    logic          full, err;
    logic [1:0]    err_code;

    instr_imm_encoder #(.IMEM_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .wr_count(wr_count), .full(full), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // model state
    int            m_count;
    logic          m_err;
    logic [1:0]    m_code;
    logic [AW+31:0] exp_q[$];
    logic          lit_en;
    logic [31:0]   lit_word;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Instruction word from the RV32I field layout, built arithmetically.
    function automatic logic [31:0] model_word(input int op, input int rd, input int rs1,
                                               input int rs2, input int imm);
        int w;
        case (op)
            0: w = ((imm & 'hFFF) << 20) | (rs1 << 15) | (2 << 12) | (rd << 7) | 'h03;
            1: w = (((imm >> 5) & 'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (2 << 12)
                   | ((imm & 'h1F) << 7) | 'h23;
            default: w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 'h3F) << 25) | (rs2 << 20)
                   | (rs1 << 15) | (((imm >> 1) & 'hF) << 8) | (((imm >> 11) & 1) << 7) | 'h63;
        endcase
        return w;
    endfunction

    // 0 = legal, else the error code the request must produce.
    function automatic int model_err(input int op, input int imm);
        if (op == 3) return 3;
        if (op < 2) return (imm < -2048 || imm > 2047) ? 1 : 0;
        if (imm < -4096 || imm > 4094) return 1;
        if (imm % 2 != 0) return 2;
        return 0;
    endfunction

    // Every write is checked against the scoreboard.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 32'd1, 32'd0);
            end else begin
                logic [AW+31:0] ent;
                ent = exp_q.pop_front();
                $display("write addr=%0d data=%h", imem_addr, imem_wdata);
                chk("write_addr", 32'(imem_addr), 32'(ent[AW+31:32]));
                chk("write_data", imem_wdata, ent[31:0]);
                if (lit_en) begin
                    chk("literal_word", imem_wdata, lit_word);
                    lit_en = 1'b0;
                end
            end
        end
    end

    task automatic drive(input int op, input int rd, input int rs1, input int rs2, input int imm);
        in_op    = 2'(op);
        in_rd    = 5'(rd);
        in_rs1   = 5'(rs1);
        in_rs2   = 5'(rs2);
        in_imm   = imm;
        in_valid = 1'b1;
    endtask

    // Call just after a negedge; returns right after the handshake edge.
    task automatic wait_hs();
        bit ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (in_ready === 1'b1) begin
                @(posedge clk);
                ok = 1;
            end else begin
                @(negedge clk);
            end
        end
        #1 in_valid = 1'b0;
        if (!ok) chk("handshake_timeout", 32'd0, 32'd1);
    endtask

    task automatic accept_and_check(input int op, input int rd, input int rs1, input int rs2,
                                    input int imm);
        int e;
        e = model_err(op, imm);
        if (e == 0) exp_q.push_back({AW'(m_count), model_word(op, rd, rs1, rs2, imm)});
        @(negedge clk);
        chk("we_in_check", 32'(imem_we), 32'd0);
        @(negedge clk);
        chk("we_at_t2", 32'(imem_we), 32'(e == 0));
        if (e == 0) m_count++;
        else if (!m_err) begin
            m_err  = 1'b1;
            m_code = 2'(e);
        end
        @(negedge clk);
        chk("wr_count", 32'(wr_count), 32'(m_count));
        chk("full", 32'(full), 32'(m_count == DEPTH));
        chk("err", 32'(err), 32'(m_err));
        chk("err_code", 32'(err_code), 32'(m_code));
        $display("req op=%0d imm=%0d -> err=%0d count=%0d", op, imm, err_code, wr_count);
    endtask

    task automatic send(input int op, input int rd, input int rs1, input int rs2, input int imm);
        @(negedge clk);
        drive(op, rd, rs1, rs2, imm);
        wait_hs();
        accept_and_check(op, rd, rs1, rs2, imm);
    endtask

    task automatic model_restart();
        chk("pending_writes", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        m_count = 0;
        m_err   = 1'b0;
        m_code  = 2'b00;
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_restart();
        #1;
        chk("clear_count", 32'(wr_count), 32'd0);
        chk("clear_err", 32'(err), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_we"}, 32'(imem_we), 32'd0);
        chk({tag, "_addr"}, 32'(imem_addr), 32'd0);
        chk({tag, "_wdata"}, imem_wdata, 32'd0);
        chk({tag, "_count"}, 32'(wr_count), 32'd0);
        chk({tag, "_full"}, 32'(full), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_code"}, 32'(err_code), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0;
        in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
        lit_en = 1'b0; lit_word = '0;
        m_count = 0; m_err = 1'b0; m_code = 2'b00;
        #1;
        check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // hand-computed encodings
        lit_en = 1'b1; lit_word = 32'hFFC12283;
        send(0, 5, 2, 0, -4);
        lit_en = 1'b1; lit_word = 32'h00612423;
        send(1, 0, 2, 6, 8);
        chk("t2_count", 32'(wr_count), 32'd2);
        lit_en = 1'b1; lit_word = 32'hFE208CE3;
        send(2, 0, 1, 2, -8);
        chk("literal_consumed", 32'(lit_en), 32'd0);
        do_clear();

        // first error sticks
        send(0, 1, 1, 0, 2048);
        chk("t4_code_range", 32'(err_code), 32'd1);
        send(2, 0, 3, 4, 6);
        send(2, 0, 3, 4, 3);
        chk("t4_code_kept", 32'(err_code), 32'd1);
        do_clear();

        // illegal op and legal boundary immediates
        send(3, 1, 1, 1, 0);
        chk("illegal_code", 32'(err_code), 32'd3);
        send(0, 1, 2, 0, 2047);
        send(1, 0, 2, 3, -2048);
        send(2, 0, 1, 1, 4094);
        send(2, 0, 1, 1, -4096);
        do_clear();

        // misaligned first, then out-of-range values
        send(2, 0, 1, 1, 5);
        chk("align_code", 32'(err_code), 32'd2);
        send(2, 0, 1, 1, 4096);
        send(2, 0, 1, 1, -4098);
        send(0, 3, 1, 0, -2049);
        send(1, 0, 1, 2, 2048);
        chk("no_writes", 32'(wr_count), 32'd0);
        do_clear();

        // fill, pend, clear
        send(0, 7, 8, 0, 100);
        send(1, 0, 9, 10, -100);
        send(2, 0, 11, 12, 2048);
        send(0, 31, 31, 0, -1);
        chk("t5_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        drive(1, 0, 4, 5, 12);
        repeat (4) begin
            @(negedge clk);
            chk("pending_ready", 32'(in_ready), 32'd0);
            chk("pending_we", 32'(imem_we), 32'd0);
        end
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_restart();
        #1;
        chk("t5_count", 32'(wr_count), 32'd0);
        chk("t5_full", 32'(full), 32'd0);
        wait_hs();
        accept_and_check(1, 0, 4, 5, 12);

        // clear during WRITE drops the write
        @(negedge clk);
        drive(0, 2, 3, 0, 16);
        wait_hs();
        @(negedge clk);
        @(posedge clk);
        #1 clear = 1'b1;
        #1 chk("clear_we_low", 32'(imem_we), 32'd0);
        @(posedge clk);
        #1 clear = 1'b0;
        model_restart();
        #1;
        chk("t6_clear_count", 32'(wr_count), 32'd0);
        chk("t6_clear_ready", 32'(in_ready), 32'd1);

        // reset during CHECK
        send(0, 1, 1, 0, 1);
        @(negedge clk);
        drive(1, 0, 1, 2, 4);
        wait_hs();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        m_count = 0; m_err = 1'b0; m_code = 2'b00;
        repeat (3) begin
            @(negedge clk);
            chk("post_reset_we", 32'(imem_we), 32'd0);
        end
        send(2, 0, 5, 6, -2);
        chk("final_queue", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
